// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the ID-stage operand fetch of the 5-stage
// MIPS pipeline.
//   DW        : datapath width
//   AW        : register address width (32 architectural registers)
//   REG_ZERO  : register number of the hardwired-zero register $0
//   fwd_sel_t : operand source chosen per read port
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int         DW       = 32;
    localparam int         AW       = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,  // array read
        FWD_WB  = 2'd1,  // writeback bypass
        FWD_MEM = 2'd2,  // MEM-stage forward
        FWD_EX  = 2'd3   // EX-stage forward
    } fwd_sel_t;

endpackage

// File: rtl/regfile_core.sv
// ----------------------------------------------------------------------------
// regfile_core
// 2^AW x DW flop-based general register file: one synchronous write port,
// two asynchronous read ports, $0 hardwired to zero (writes ignored).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (clears array)
//   we, waddr, wdata   : write port, sampled on the rising edge
//   raddr_a / rdata_a  : asynchronous read port A
//   raddr_b / rdata_b  : asynchronous read port B
// ----------------------------------------------------------------------------
module regfile_core #(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    import pipe_pkg::*;

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs [NREG];

    // NOTE: this array is built from flops, so it may (and must) take the
    // asynchronous reset; an SRAM macro could not be cleared this way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != AW'(REG_ZERO))) begin
            regs[waddr] <= wdata;
        end
    end

    // $0 is forced on the read side as well, so entry 0 never matters.
    assign rdata_a = (raddr_a == AW'(REG_ZERO)) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == AW'(REG_ZERO)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/pipe_id_operand.sv
// ----------------------------------------------------------------------------
// pipe_id_operand
// ID-stage operand fetch: register file, RAW hazard resolution against
// EX / MEM / WB (forward or stall) and the ID/EX operand latch.
// Build option: define PIPE_ID_FWD_EN to compile in EX/MEM forwarding
// (only load-use hazards stall). Without it every EX/MEM hazard stalls until
// the producer reaches WB. The WB bypass and $0 handling exist in both builds.
// Ports:
//   clk, rst_n                           : clock, async active-low reset
//   id_valid, rs/rt_addr, rs/rt_used     : instruction in ID
//   ex_waddr/wena/is_load/data           : EX-stage producer
//   mem_waddr/wena/data                  : MEM-stage producer
//   wb_rf_waddr/wb_rf_wena/rf_wdata      : writeback (regfile write port)
//   flush                                : squash ID/EX
//   stall                                : combinational hold of PC / IF/ID
//   idex_valid, idex_rs_data/rt_data     : ID/EX latch outputs
// ----------------------------------------------------------------------------
module pipe_id_operand #(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          rs_used,
    input  logic          rt_used,
    input  logic [AW-1:0] ex_waddr,
    input  logic          ex_wena,
    input  logic          ex_is_load,
    input  logic [DW-1:0] ex_data,
    input  logic [AW-1:0] mem_waddr,
    input  logic          mem_wena,
    input  logic [DW-1:0] mem_data,
    input  logic [AW-1:0] wb_rf_waddr,
    input  logic          wb_rf_wena,
    input  logic [DW-1:0] rf_wdata,
    input  logic          flush,
    output logic          stall,
    output logic          idex_valid,
    output logic [DW-1:0] idex_rs_data,
    output logic [DW-1:0] idex_rt_data
);
    import pipe_pkg::*;

    logic [DW-1:0] rf_rs_q, rf_rt_q;
    logic          rs_ex, rs_mem, rs_wb;
    logic          rt_ex, rt_mem, rt_wb;
    fwd_sel_t      rs_sel, rt_sel;
    logic [DW-1:0] rs_operand, rt_operand;

    regfile_core #(.DW(DW), .AW(AW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_rf_wena),
        .waddr   (wb_rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs_addr),
        .rdata_a (rf_rs_q),
        .raddr_b (rt_addr),
        .rdata_b (rf_rt_q)
    );

    // A source matches a stage only if it is consumed, is not $0, and the
    // stage really writes that register.
    function automatic logic src_match(input logic          used,
                                       input logic [AW-1:0] src,
                                       input logic          wena,
                                       input logic [AW-1:0] waddr);
        return used && (src != AW'(REG_ZERO)) && wena && (waddr == src);
    endfunction

    assign rs_ex  = src_match(rs_used, rs_addr, ex_wena,    ex_waddr);
    assign rs_mem = src_match(rs_used, rs_addr, mem_wena,   mem_waddr);
    assign rs_wb  = src_match(rs_used, rs_addr, wb_rf_wena, wb_rf_waddr);
    assign rt_ex  = src_match(rt_used, rt_addr, ex_wena,    ex_waddr);
    assign rt_mem = src_match(rt_used, rt_addr, mem_wena,   mem_waddr);
    assign rt_wb  = src_match(rt_used, rt_addr, wb_rf_wena, wb_rf_waddr);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rs_sel = FWD_RF;
        rt_sel = FWD_RF;
`ifdef PIPE_ID_FWD_EN
        // Youngest producer wins: EX over MEM over WB.
        if (rs_ex)       rs_sel = FWD_EX;
        else if (rs_mem) rs_sel = FWD_MEM;
        else if (rs_wb)  rs_sel = FWD_WB;
        if (rt_ex)       rt_sel = FWD_EX;
        else if (rt_mem) rt_sel = FWD_MEM;
        else if (rt_wb)  rt_sel = FWD_WB;
`else
        if (rs_wb) rs_sel = FWD_WB;
        if (rt_wb) rt_sel = FWD_WB;
`endif
    end

    function automatic logic [DW-1:0] operand_mux(input fwd_sel_t      sel,
                                                  input logic [DW-1:0] rf_q);
        case (sel)
`ifdef PIPE_ID_FWD_EN
            FWD_EX:  return ex_data;
            FWD_MEM: return mem_data;
`endif
            FWD_WB:  return rf_wdata;
            default: return rf_q;
        endcase
    endfunction

    assign rs_operand = operand_mux(rs_sel, rf_rs_q);
    assign rt_operand = operand_mux(rt_sel, rf_rt_q);

`ifdef PIPE_ID_FWD_EN
    // Only a load in EX cannot be forwarded; it reaches MEM next cycle.
    assign stall = id_valid && ex_is_load && (rs_ex || rt_ex);
`else
    // Hold until the producer reaches WB, where the bypass covers it.
    assign stall = id_valid && (rs_ex || rt_ex || rs_mem || rt_mem);

    // EX/MEM data and load type are not consumed without forwarding.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_data, mem_data, ex_is_load};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid   <= 1'b0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
        end else if (flush) begin
            idex_valid   <= 1'b0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
        end else if (stall) begin
            // Bubble into EX while PC and IF/ID hold.
            idex_valid   <= 1'b0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
        end else begin
            idex_valid   <= id_valid;
            idex_rs_data <= rs_operand;
            idex_rt_data <= rt_operand;
        end
    end

endmodule

// File: tb/tb_pipe_id_operand.sv
// ----------------------------------------------------------------------------
// tb_pipe_id_operand
// Directed self-checking bench for pipe_id_operand. Covers both builds:
// forwarding scenarios when PIPE_ID_FWD_EN is defined, stall-to-WB otherwise.
// ----------------------------------------------------------------------------
module tb_pipe_id_operand;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] rs_addr, rt_addr;
    logic          rs_used, rt_used;
    logic [AW-1:0] ex_waddr;
    logic          ex_wena, ex_is_load;
    logic [DW-1:0] ex_data;
    logic [AW-1:0] mem_waddr;
    logic          mem_wena;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] wb_rf_waddr;
    logic          wb_rf_wena;
    logic [DW-1:0] rf_wdata;
    logic          flush;
    logic          stall;
    logic          idex_valid;
    logic [DW-1:0] idex_rs_data, idex_rt_data;

    int tests = 0;
    int fails = 0;

    pipe_id_operand #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_used      (rs_used),
        .rt_used      (rt_used),
        .ex_waddr     (ex_waddr),
        .ex_wena      (ex_wena),
        .ex_is_load   (ex_is_load),
        .ex_data      (ex_data),
        .mem_waddr    (mem_waddr),
        .mem_wena     (mem_wena),
        .mem_data     (mem_data),
        .wb_rf_waddr  (wb_rf_waddr),
        .wb_rf_wena   (wb_rf_wena),
        .rf_wdata     (rf_wdata),
        .flush        (flush),
        .stall        (stall),
        .idex_valid   (idex_valid),
        .idex_rs_data (idex_rs_data),
        .idex_rt_data (idex_rt_data)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; rs_addr = '0; rt_addr = '0; rs_used = 0; rt_used = 0;
        ex_waddr = '0; ex_wena = 0; ex_is_load = 0; ex_data = '0;
        mem_waddr = '0; mem_wena = 0; mem_data = '0;
        wb_rf_waddr = '0; wb_rf_wena = 0; rf_wdata = '0; flush = 0;
    endtask

    task automatic read_pair(input int a, input int b);
        id_valid = 1; rs_used = 1; rt_used = 1;
        rs_addr = a[AW-1:0]; rt_addr = b[AW-1:0];
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick(); tick();
        tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", idex_valid); end
        tests++; if (idex_rs_data !== '0) begin fails++; $display("FAIL reset_rs: got %h want 0", idex_rs_data); end
        tests++; if (idex_rt_data !== '0) begin fails++; $display("FAIL reset_rt: got %h want 0", idex_rt_data); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_stall_gating();
        // Hazard inputs present but no valid instruction / only $0 matches.
        idle();
        rs_addr = 5'd4; rs_used = 1; ex_wena = 1; ex_waddr = 5'd4; ex_is_load = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_no_valid: got %0b want 0", stall); end
        id_valid = 1; rs_addr = 5'd0; ex_waddr = 5'd0; mem_wena = 1; mem_waddr = 5'd0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_zero_reg: got %0b want 0", stall); end
        idle();
    endtask

    task automatic test_wb_bypass();
        idle();
        id_valid = 1; rs_used = 1; rs_addr = 5'd5;
        wb_rf_wena = 1; wb_rf_waddr = 5'd5; rf_wdata = 32'h1234_5678;
        tick();
        tests++; if (idex_rs_data !== 32'h1234_5678) begin fails++; $display("FAIL wb_bypass: got %h want 12345678", idex_rs_data); end
        tests++; if (idex_valid !== 1'b1) begin fails++; $display("FAIL wb_bypass_valid: got %0b want 1", idex_valid); end
        wb_rf_wena = 0; rf_wdata = '0;
        tick();
        tests++; if (idex_rs_data !== 32'h1234_5678) begin fails++; $display("FAIL rf_written: got %h want 12345678", idex_rs_data); end
        rs_addr = 5'd0; wb_rf_wena = 1; wb_rf_waddr = 5'd0; rf_wdata = 32'hFFFF_FFFF;
        tick();
        tests++; if (idex_rs_data !== '0) begin fails++; $display("FAIL r0_bypass: got %h want 0", idex_rs_data); end
        wb_rf_wena = 0; rf_wdata = '0;
        tick();
        tests++; if (idex_rs_data !== '0) begin fails++; $display("FAIL r0_read: got %h want 0", idex_rs_data); end
        idle();
    endtask

    // Fill r1..r31 with 0x1000_0000 + n, then read them back-to-back in
    // pairs (rs = n, rt = 32 - n): each cycle's result lands one cycle later.
    task automatic test_back_to_back();
        logic [DW-1:0] exp_rs, exp_rt;
        idle();
        for (int n = 1; n < 32; n++) begin
            wb_rf_wena = 1; wb_rf_waddr = n[AW-1:0]; rf_wdata = 32'h1000_0000 + n;
            tick();
        end
        idle();
        for (int n = 1; n < 32; n++) begin
            read_pair(n, 32 - n);
            tick();
            exp_rs = 32'h1000_0000 + n;
            exp_rt = 32'h1000_0000 + (32 - n);
            tests++; if (idex_rs_data !== exp_rs) begin fails++; $display("FAIL b2b_rs[%0d]: got %h want %h", n, idex_rs_data, exp_rs); end
            tests++; if (idex_rt_data !== exp_rt) begin fails++; $display("FAIL b2b_rt[%0d]: got %h want %h", n, idex_rt_data, exp_rt); end
        end
        idle();
    endtask

`ifdef PIPE_ID_FWD_EN
    task automatic test_forward_priority();
        idle();
        read_pair(7, 7);
        ex_wena = 1;    ex_waddr = 5'd7;    ex_data = 32'hA;
        mem_wena = 1;   mem_waddr = 5'd7;   mem_data = 32'hB;
        wb_rf_wena = 1; wb_rf_waddr = 5'd7; rf_wdata = 32'hC;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fwd_no_stall: got %0b want 0", stall); end
        tick();
        tests++; if (idex_rs_data !== 32'hA) begin fails++; $display("FAIL fwd_ex_rs: got %h want a", idex_rs_data); end
        tests++; if (idex_rt_data !== 32'hA) begin fails++; $display("FAIL fwd_ex_rt: got %h want a", idex_rt_data); end
        ex_wena = 0;
        tick();
        tests++; if (idex_rs_data !== 32'hB) begin fails++; $display("FAIL fwd_mem: got %h want b", idex_rs_data); end
        mem_wena = 0;
        tick();
        tests++; if (idex_rs_data !== 32'hC) begin fails++; $display("FAIL fwd_wb: got %h want c", idex_rs_data); end
        wb_rf_wena = 0;
        tick();
        tests++; if (idex_rs_data !== 32'hC) begin fails++; $display("FAIL fwd_rf: got %h want c", idex_rs_data); end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        read_pair(2, 3);
        ex_wena = 1; ex_waddr = 5'd3; ex_is_load = 1; ex_data = 32'h5A5A_5A5A;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %0b want 1", stall); end
        tick();
        tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble_valid: got %0b want 0", idex_valid); end
        tests++; if (idex_rt_data !== '0) begin fails++; $display("FAIL lu_bubble_rt: got %h want 0", idex_rt_data); end
        // Load advances to MEM; same instruction retries in ID.
        ex_wena = 0; ex_is_load = 0;
        mem_wena = 1; mem_waddr = 5'd3; mem_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_one_cycle: got %0b want 0", stall); end
        tick();
        tests++; if (idex_valid !== 1'b1) begin fails++; $display("FAIL lu_valid: got %0b want 1", idex_valid); end
        tests++; if (idex_rt_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lu_mem_fwd: got %h want deadbeef", idex_rt_data); end
        tests++; if (idex_rs_data !== 32'h1000_0002) begin fails++; $display("FAIL lu_rs: got %h want 10000002", idex_rs_data); end
        // A non-load EX producer is forwarded, not stalled.
        mem_wena = 0; ex_wena = 1; ex_waddr = 5'd3; ex_is_load = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_alu_nostall: got %0b want 0", stall); end
        ex_is_load = 1; rt_used = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_unused: got %0b want 0", stall); end
        idle();
    endtask
`else
    task automatic test_nofwd_stall();
        idle();
        id_valid = 1; rs_used = 1; rs_addr = 5'd9;
        ex_wena = 1; ex_waddr = 5'd9; ex_data = 32'h5555;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL nf_stall_ex: got %0b want 1", stall); end
        tick();
        tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL nf_bubble1: got %0b want 0", idex_valid); end
        ex_wena = 0; mem_wena = 1; mem_waddr = 5'd9; mem_data = 32'h6666;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL nf_stall_mem: got %0b want 1", stall); end
        tick();
        tests++; if (idex_rs_data !== '0) begin fails++; $display("FAIL nf_bubble2: got %h want 0", idex_rs_data); end
        mem_wena = 0; wb_rf_wena = 1; wb_rf_waddr = 5'd9; rf_wdata = 32'h99;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nf_stall_wb: got %0b want 0", stall); end
        tick();
        tests++; if (idex_rs_data !== 32'h99) begin fails++; $display("FAIL nf_wb_operand: got %h want 99", idex_rs_data); end
        tests++; if (idex_valid !== 1'b1) begin fails++; $display("FAIL nf_valid: got %0b want 1", idex_valid); end
        wb_rf_wena = 0; ex_wena = 1; ex_waddr = 5'd9; rs_used = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nf_unused: got %0b want 0", stall); end
        idle();
    endtask
`endif

    task automatic test_flush();
        idle();
        read_pair(1, 2);
        tick();
        tests++; if (idex_rs_data !== 32'h1000_0001) begin fails++; $display("FAIL fl_pre_rs: got %h want 10000001", idex_rs_data); end
        // Load on rs in EX stalls in both builds; flush is raised as well.
        ex_wena = 1; ex_waddr = 5'd1; ex_is_load = 1; flush = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fl_stall_seen: got %0b want 1", stall); end
        tick();
        tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL fl_stall_valid: got %0b want 0", idex_valid); end
        tests++; if ({idex_rs_data, idex_rt_data} !== '0) begin fails++; $display("FAIL fl_stall_data: got %h/%h want 0", idex_rs_data, idex_rt_data); end
        ex_wena = 0; ex_is_load = 0; flush = 0;
        tick();
        tests++; if (idex_valid !== 1'b1) begin fails++; $display("FAIL fl_reload: got %0b want 1", idex_valid); end
        flush = 1;
        tick();
        tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL fl_alone_valid: got %0b want 0", idex_valid); end
        tests++; if (idex_rt_data !== '0) begin fails++; $display("FAIL fl_alone_rt: got %h want 0", idex_rt_data); end
        idle();
    endtask

    task automatic test_reset_mid_run();
        idle();
        read_pair(3, 4);
        tick();
        tests++; if (idex_rt_data !== 32'h1000_0004) begin fails++; $display("FAIL rm_pre: got %h want 10000004", idex_rt_data); end
        #2 rst_n = 0;
        #1;
        tests++; if (idex_valid !== 1'b0) begin fails++; $display("FAIL rm_async_valid: got %0b want 0", idex_valid); end
        tests++; if ({idex_rs_data, idex_rt_data} !== '0) begin fails++; $display("FAIL rm_async_data: got %h/%h want 0", idex_rs_data, idex_rt_data); end
        tick();
        rst_n = 1;
        for (int n = 0; n < 32; n++) begin
            read_pair(n, 31 - n);
            tick();
            tests++; if (idex_rs_data !== '0) begin fails++; $display("FAIL rm_clear_rs[%0d]: got %h want 0", n, idex_rs_data); end
            tests++; if (idex_rt_data !== '0) begin fails++; $display("FAIL rm_clear_rt[%0d]: got %h want 0", 31 - n, idex_rt_data); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stall_gating();
        test_wb_bypass();
        test_back_to_back();
`ifdef PIPE_ID_FWD_EN
        test_forward_priority();
        test_load_use();
`else
        test_nofwd_stall();
`endif
        test_flush();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_id_operand.md
# pipe_id_operand

Operand-fetch block for the ID stage of the 5-stage MIPS pipeline. Holds the 32x32 general register file and takes the writeback write port (`rf_wdata`, `wb_rf_waddr`, `wb_rf_wena`). Reads the rs and rt operands and resolves RAW hazards against EX, MEM and WB, by forwarding or by stall. Registers the resolved operands into the ID/EX latch.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 5: register address width (32 registers).

Ports (clock and reset first):
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `rs_addr`, `rt_addr`  in  AW  source register numbers.
- `rs_used`, `rt_used`  in  1  instruction actually consumes rs / rt.
- `ex_waddr`  in  AW  EX-stage destination.
- `ex_wena`  in  1  EX instruction writes the regfile.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_data`  in  DW  EX ALU result.
- `mem_waddr`  in  AW  MEM-stage destination.
- `mem_wena`  in  1  MEM instruction writes the regfile.
- `mem_data`  in  DW  MEM result (ALU or load data).
- `wb_rf_waddr`  in  AW  writeback destination.
- `wb_rf_wena`  in  1  writeback enable.
- `rf_wdata`  in  DW  writeback data.
- `flush`  in  1  squash ID/EX (branch/jump redirect).
- `stall`  out  1  combinational; hold PC and IF/ID this cycle.
- `idex_valid`  out  1  ID/EX latch holds a real instruction.
- `idex_rs_data`, `idex_rt_data`  out  DW  registered operands.

## Operation
- Register file: 32 x DW flops. Written at the rising edge when `wb_rf_wena` is high and `wb_rf_waddr` != 0. Writes to $0 are ignored, and $0 always reads 0.
- Source match: a source matches a stage when that source is used, its address is non-zero, the stage's wena is high, and the stage's waddr equals the address.
- With `FWD_EN`, operand selection priority per source:
  - EX match: `ex_data`.
  - Otherwise MEM match: `mem_data`.
  - Otherwise WB match: `rf_wdata`.
  - Otherwise: array read.
  - `stall` = `id_valid` & any source matches EX & `ex_is_load` (load-use hazard).
- Without `FWD_EN`, operand selection: WB match gives `rf_wdata`, otherwise the array read. `stall` = `id_valid` & any source matches EX or MEM.
- WB bypass is always present, so the array needs no write-before-read ordering.
- ID/EX latch update at each rising edge, in priority order:
  - `flush`: `idex_valid` <= 0, both data <= 0.
  - `stall`: bubble, i.e. `idex_valid` <= 0, data <= 0.
  - Otherwise: `idex_valid` <= `id_valid`, data <= selected operands.
- `flush` and `stall` together: flush wins. The result is identical (a bubble), but it must be coded as flush.

## Timing
- Reset (async, `rst_n` low): all 32 registers, `idex_valid`, `idex_rs_data` and `idex_rt_data` go to 0 immediately. `stall` is combinational and is 0 whenever `id_valid` = 0.
- Reset mid-operation discards any in-flight bubble. There is no stall state to clear, because `stall` is stateless.
- Operand latency: 1 cycle from ID inputs to `idex_*`.
- Regfile write latency: 1 cycle. Same-cycle reads see the new value through the WB bypass.
- A load-use stall lasts exactly 1 cycle with `FWD_EN`, since the load then moves to MEM.
- Without `FWD_EN`, a stall lasts up to 2 cycles: the hazard moves from EX to MEM to WB, and WB is bypassed.
- `stall` depends only on current-cycle inputs. There is no combinational path from `idex_*` back to `stall`.

## Configuration
- `PIPE_ID_FWD_EN` defined: EX and MEM forwarding paths are compiled in, and only load-use hazards stall.
- `PIPE_ID_FWD_EN` undefined: no EX/MEM forwarding muxes. Every EX/MEM RAW hazard stalls until the producer reaches WB.
- The WB bypass and $0 handling are present in both builds.

## Structure
- Shared package `pipe_pkg`: `DW`, `AW`, `REG_ZERO` (5'd0), and a typedef `fwd_sel_t` with values `FWD_RF`, `FWD_WB`, `FWD_MEM`, `FWD_EX`.
- One sub-module, `regfile_core`: the 32xDW array with one write port, two asynchronous read ports and $0 hardwired to 0.
- Forwarding select, hazard detect and the ID/EX latch live in `pipe_id_operand`.

## Test plan
- Reset: pulse `rst_n` low mid-run -> `idex_valid` = 0 and data = 0 asynchronously; reading all 32 registers afterwards returns 0.
- WB bypass: `wb_rf_waddr` = 5, `rf_wdata` = 0x1234_5678, `rs_addr` = 5 in the same cycle -> `idex_rs_data` = 0x1234_5678 next cycle. Writing 0xFFFF_FFFF to $0 then reading $0 -> 0.
- Forward priority (FWD_EN): rs = 7 matches EX (0xA), MEM (0xB) and WB (0xC) simultaneously -> `idex_rs_data` = 0xA. With only MEM and WB matching -> 0xB.
- Load-use (FWD_EN): `ex_is_load` = 1, `ex_waddr` = 3, `rt_addr` = 3, `rt_used` = 1 -> `stall` = 1 for exactly 1 cycle and a bubble enters ID/EX. On the next cycle the MEM forward delivers the load data.
- No-FWD build: `ex_waddr` = 9 hazard on rs -> `stall` = 1 for 2 cycles, then the operand comes from the WB bypass. With `rs_used` = 0 -> no stall.
- Flush during stall: `flush` = 1 and `stall` = 1 -> `idex_valid` = 0 and data = 0. `flush` = 1 alone with `id_valid` = 1 -> `idex_valid` = 0.
